// File: rtl/residual_packer.sv
// residual_packer
//   Final stage of the block-compression pipeline. Takes one record per
//   32-pixel RGBA block, works out a bit width per channel, emits a header
//   word and then packs the residuals LSB-first onto a 64-bit stream.
//
// Ports
//   clk              clock
//   rst_n            asynchronous active-low reset; drops any block in flight
//   in_valid         input record valid
//   in_ready         high while idle; a record is taken on in_valid&&in_ready
//   in_residuals     pixel i at [32*i +: 32]; r,g,b,a bytes at +0,+8,+16,+24
//   in_header        raw 48-bit header; bits 47..44 are skip_r/g/b/a
//   in_compressable  0: residual field carries raw pixel bytes (all widths 8)
//   out_valid        output word valid
//   out_ready        downstream accepts the word
//   out_data         packed output word
//   out_last         marks the final word of a block
module residual_packer #(
    parameter int NUM_PIX = 32,
    parameter int OUT_W   = 64,
    parameter int GROUP   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PIX*32-1:0]  in_residuals,
    input  logic [47:0]            in_header,
    input  logic                   in_compressable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_last
);

    localparam int ACC_W = 2 * OUT_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HDR   = 2'd1;
    localparam logic [1:0] S_PACK  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    // Number of significant bits in an 8-bit value (0..8).
    function automatic logic [3:0] bit_len(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) n = 4'(b + 1);
        end
        return n;
    endfunction

    // First channel at or after 'from' with a nonzero width; 4 means none.
    function automatic logic [2:0] next_chan(input logic [3:0][3:0] w, input int from);
        logic [2:0] r;
        r = 3'd4;
        for (int c = 3; c >= 0; c--) begin
            if (c >= from && w[c] != 4'd0) r = 3'(c);
        end
        return r;
    endfunction

    // Control state (reset)
    logic [1:0]              r_state;
    logic [7:0]              r_fill;
    logic [1:0]              r_ch;
    logic [1:0]              r_sub;

    // Record and accumulator contents (not reset; outputs are masked by state)
    logic [NUM_PIX*32-1:0]   r_res;
    logic [OUT_W-1:0]        r_hdr_word;
    logic [3:0][3:0]         r_w;
    logic [ACC_W-1:0]        r_acc;

    // Width computation on the incoming record
    logic [3:0][7:0]         w_or;
    logic [3:0][3:0]         w_cap_w;
    logic [3:0]              w_skip;
    logic [OUT_W-1:0]        w_cap_hdr;

    always_comb begin
        w_or = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            for (int c = 0; c < 4; c++) begin
                w_or[c] = w_or[c] | in_residuals[32*i + 8*c +: 8];
            end
        end
        // Skip flags only have meaning for compressable blocks.
        w_skip = in_compressable ? in_header[47:44] : 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (!in_compressable) begin
                w_cap_w[c] = 4'd8;
            end else if (w_skip[3-c]) begin
                w_cap_w[c] = 4'd0;
            end else begin
                w_cap_w[c] = bit_len(w_or[c]);
            end
        end
        w_cap_hdr = {w_skip, in_header[43:0],
                     w_cap_w[0], w_cap_w[1], w_cap_w[2], w_cap_w[3]};
    end

    // Packing datapath
    logic [5:0]              w_sum;
    logic [2:0]              w_first;
    logic [3:0]              w_cur_w;
    logic [8:0]              w_mask9;
    logic [7:0]              w_mask;
    logic [OUT_W-1:0]        w_grp;
    logic                    w_pop;
    logic [7:0]              w_fill_ap;
    logic [ACC_W-1:0]        w_acc_ap;
    logic                    w_append;
    logic [7:0]              w_fill_new;
    logic [2:0]              w_nxt_ch;
    logic                    w_last_grp;
    logic [ACC_W-1:0]        w_acc_nxt;

    always_comb begin
        w_sum   = {2'b00, r_w[0]} + {2'b00, r_w[1]} + {2'b00, r_w[2]} + {2'b00, r_w[3]};
        w_first = next_chan(r_w, 0);
        w_cur_w = r_w[r_ch];
        w_mask9 = (9'd1 << w_cur_w) - 9'd1;
        w_mask  = w_mask9[7:0];

        // One group: 8 residuals of the current channel, each w bits wide.
        w_grp = '0;
        for (int j = 0; j < GROUP; j++) begin
            w_grp = w_grp | (OUT_W'(r_res[32*(GROUP*int'(r_sub) + j) + 8*int'(r_ch) +: 8] & w_mask)
                             << (j * int'(w_cur_w)));
        end

        // The header word never touches the accumulator.
        w_pop     = out_valid && out_ready && (r_state != S_HDR);
        w_fill_ap = w_pop ? r_fill - 8'd64 : r_fill;
        w_acc_ap  = w_pop ? (r_acc >> OUT_W) : r_acc;

        // Append only once the post-pop fill leaves room for a full group.
        w_append   = (r_state == S_PACK) && (w_fill_ap < 8'd64);
        w_fill_new = w_fill_ap + {1'b0, w_cur_w, 3'b000};
        w_nxt_ch   = (r_sub == 2'd3) ? next_chan(r_w, int'(r_ch) + 1) : {1'b0, r_ch};
        w_last_grp = (r_sub == 2'd3) && w_nxt_ch[2];

        case (r_state)
            S_IDLE:  w_acc_nxt = '0;
            S_HDR:   w_acc_nxt = r_acc;
            S_PACK:  w_acc_nxt = w_append ? (w_acc_ap | (ACC_W'(w_grp) << w_fill_ap)) : w_acc_ap;
            default: w_acc_nxt = w_acc_ap;
        endcase
    end

    always_ff @(posedge clk) begin
        r_acc <= w_acc_nxt;
        if (r_state == S_IDLE && in_valid) begin
            r_res      <= in_residuals;
            r_hdr_word <= w_cap_hdr;
            r_w        <= w_cap_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_fill  <= 8'd0;
            r_ch    <= 2'd0;
            r_sub   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_HDR;
                        r_fill  <= 8'd0;
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        if (w_sum == 6'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_PACK;
                            r_ch    <= w_first[1:0];
                            r_sub   <= 2'd0;
                        end
                    end
                end
                S_PACK: begin
                    r_fill <= w_append ? w_fill_new : w_fill_ap;
                    if (w_append) begin
                        r_sub <= r_sub + 2'd1;
                        r_ch  <= w_nxt_ch[1:0];
                        if (w_last_grp) r_state <= S_FLUSH;
                    end
                end
                default: begin
                    // Remaining bits may still span two words (fill up to 127).
                    if (out_ready) begin
                        if (r_fill <= 8'd64) begin
                            r_state <= S_IDLE;
                            r_fill  <= 8'd0;
                        end else begin
                            r_fill <= r_fill - 8'd64;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == S_IDLE);
        case (r_state)
            S_HDR: begin
                out_valid = 1'b1;
                out_last  = (w_sum == 6'd0);
                out_data  = r_hdr_word;
            end
            S_PACK: begin
                out_valid = (r_fill >= 8'd64);
                out_last  = 1'b0;
                out_data  = r_acc[OUT_W-1:0];
            end
            S_FLUSH: begin
                out_valid = 1'b1;
                out_last  = (r_fill <= 8'd64);
                out_data  = r_acc[OUT_W-1:0];
            end
            default: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
                out_data  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_residual_packer.sv
module tb_residual_packer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_residuals;
    logic [47:0]   in_header;
    logic          in_compressable;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic          out_last;

    always #5 clk = ~clk;

    residual_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_residuals    (in_residuals),
        .in_header       (in_header),
        .in_compressable (in_compressable),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  res [4][32];
    logic [47:0] hdr;
    logic        comp;
    int          exp_w [4];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    logic        got_l [$];
    logic [63:0] saved_q [$];
    bit          stab_ok, busy_ok, timeout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] getw(input int k);
        if (k < got_q.size()) return got_q[k];
        return 'x;
    endfunction

    // Reference: widths from the largest residual, bit list in channel/pixel order.
    task automatic model();
        bit          bits [$];
        int          m;
        logic [47:0] h;
        logic [63:0] word;
        int          nw;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            if (!comp) exp_w[c] = 8;
            else if (hdr[47-c]) exp_w[c] = 0;
            else begin
                m = 0;
                for (int i = 0; i < 32; i++) if (int'(res[c][i]) > m) m = int'(res[c][i]);
                exp_w[c] = 0;
                while ((1 << exp_w[c]) <= m) exp_w[c]++;
            end
        end
        h = hdr;
        if (!comp) h[47:44] = 4'b0;
        exp_q.push_back({h, 4'(exp_w[0]), 4'(exp_w[1]), 4'(exp_w[2]), 4'(exp_w[3])});
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 32; i++)
                for (int b = 0; b < exp_w[c]; b++) bits.push_back(res[c][i][b]);
        nw = (bits.size() + 63) / 64;
        for (int k = 0; k < nw; k++) begin
            word = '0;
            for (int b = 0; b < 64; b++)
                if (64*k + b < bits.size()) word[b] = bits[64*k + b];
            exp_q.push_back(word);
        end
    endtask

    task automatic send();
        @(negedge clk);
        for (int i = 0; i < 32; i++)
            for (int c = 0; c < 4; c++) in_residuals[32*i + 8*c +: 8] = res[c][i];
        in_header       = hdr;
        in_compressable = comp;
        in_valid        = 1'b1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("hdr_latency", 64'(out_valid), 64'd1);
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random
    task automatic collect(input int mode, input int stop_after);
        int          cyc;
        bit          stalled, done;
        logic [63:0] pd;
        logic        pl;
        cyc = 0; stalled = 0; done = 0; pd = '0; pl = 1'b0;
        got_q.delete(); got_l.delete();
        stab_ok = 1; busy_ok = 1; timeout = 0;
        while (!done) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) stab_ok = 0;
            if (in_ready !== 1'b0) busy_ok = 0;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_l.push_back(out_last);
                if (out_last || got_q.size() == stop_after) done = 1;
                stalled = 0;
            end else begin
                stalled = out_valid;
                pd = out_data;
                pl = out_last;
            end
            cyc++;
            if (cyc > 2000) begin
                timeout = 1;
                done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s_w%0d", tag, k), getw(k), exp_q[k]);
            if (k < got_l.size())
                chk($sformatf("%s_last%0d", tag, k), 64'(got_l[k]), 64'(k == exp_q.size() - 1));
        end
        chk({tag, "_stable"}, 64'(stab_ok), 64'd1);
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    task automatic clear_res();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 32; i++) res[c][i] = 8'h00;
    endtask

    task automatic gen_random();
        int w;
        comp = ($urandom_range(0, 3) != 0);
        hdr  = {16'($urandom), 32'($urandom)};
        for (int c = 0; c < 4; c++) begin
            w = $urandom_range(0, 8);
            for (int i = 0; i < 32; i++) res[c][i] = 8'($urandom & ((1 << w) - 1));
        end
    endtask

    logic [63:0] pat;
    logic [63:0] raw_w1;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_residuals = '0; in_header = '0; in_compressable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;

        // Zero block: header word only
        clear_res(); comp = 1'b1; hdr = 48'h0000_1122_3344;
        model(); send(); collect(0, 0);
        chk("zero_word", getw(0), 64'h0000_1122_3344_0000);
        compare("zero");

        // Narrow single channel: r residuals all 5
        clear_res(); comp = 1'b1; hdr = 48'h0;
        for (int i = 0; i < 32; i++) res[0][i] = 8'd5;
        model(); send(); collect(0, 0);
        for (int k = 0; k < 64; k++) pat[k] = (k % 3 != 1);
        chk("narrow_hdr", getw(0), 64'h0000_0000_0000_3000);
        chk("narrow_w1", getw(1), pat);
        chk("narrow_w2_hi", 64'(getw(2) >> 32), 64'd0);
        compare("narrow");

        // Skip g with mixed widths 1,0,8,2
        comp = 1'b1; hdr = {4'b0100, 44'($urandom)};
        for (int i = 0; i < 32; i++) begin
            res[0][i] = 8'($urandom_range(0, 1));
            res[1][i] = 8'($urandom_range(1, 255));
            res[2][i] = 8'($urandom);
            res[3][i] = 8'($urandom_range(0, 3));
        end
        res[0][0] = 8'd1; res[2][3] = 8'd255; res[3][5] = 8'd3;
        model(); send(); collect(0, 0);
        chk("mixed_widths", 64'(getw(0) & 64'hFFFF), 64'h1082);
        chk("mixed_a0_at288", 64'((getw(5) >> 32) & 64'h3), 64'(res[3][0] & 8'h3));
        compare("mixed");

        // Raw mode with skip_r set in the header
        comp = 1'b0; hdr = {4'b1000, 44'($urandom)};
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 32; i++) res[c][i] = 8'($urandom);
        model(); send(); collect(0, 0);
        for (int i = 0; i < 8; i++) raw_w1[8*i +: 8] = res[0][i];
        chk("raw_skipbits", 64'(getw(0) >> 60), 64'd0);
        chk("raw_widths", 64'(getw(0) & 64'hFFFF), 64'h8888);
        chk("raw_w1", getw(1), raw_w1);
        saved_q = got_q;
        compare("raw");

        // Same block under 1,0,0,1 back-pressure
        send(); collect(1, 0);
        chk("bp_count_vs_unstalled", 64'(got_q.size()), 64'(saved_q.size()));
        for (int k = 0; k < saved_q.size(); k++)
            chk($sformatf("bp_same_w%0d", k), getw(k), saved_q[k]);
        compare("bp");

        // Reset mid-PACK, then a fresh block
        send(); collect(0, 2);
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_res(); comp = 1'b1; hdr = 48'h0;
        for (int i = 0; i < 32; i++) res[0][i] = 8'd5;
        model(); send(); collect(0, 0);
        compare("after_rst");

        // Randomized records with random back-pressure
        for (int t = 0; t < 6; t++) begin
            gen_random();
            model(); send(); collect(2, 0);
            compare($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
